rv32ic_fetch_aligner: RTL and testbench

//   Front-end parcel aligner for RV32IC: accepts 32-bit-aligned fetch words, splits them into 16-bit parcels,

---
 rtl/rv32ic_fetch_aligner_pkg.sv | 17 +
 rtl/rv32ic_parcel_fifo.sv | 56 +++++
 rtl/rv32ic_fetch_aligner.sv | 148 ++++++++++++++
 tb/tb_rv32ic_fetch_aligner.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32ic_fetch_aligner_pkg.sv
// rv32ic_fetch_aligner_pkg: parcel types and step constants
// shared by the fetch aligner and its parcel buffer.
package rv32ic_fetch_aligner_pkg;

  localparam int PARCEL_W   = 16;
  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0]  RVC_QMASK = 2'b11;
  localparam logic [31:0] PC_STEP_C = 32'd2;
  localparam logic [31:0] PC_STEP_I = 32'd4;

  typedef struct packed {
    logic                err;
    logic [PARCEL_W-1:0] data;
  } parcel_t;

endpackage

// File: rtl/rv32ic_parcel_fifo.sv
// rv32ic_parcel_fifo: 4-entry parcel ring, push 1 or 2,
// pop 0..2 per cycle, with per-entry fault bit.
module rv32ic_parcel_fifo
  import rv32ic_fetch_aligner_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic        hi_only_i,
  input  logic [31:0] data_i,
  input  logic        err_i,
  input  logic [1:0]  pop_i,
  output parcel_t     h0_o,
  output parcel_t     h1_o,
  output logic [2:0]  count_o
);

  parcel_t    mem_q [FIFO_DEPTH];
  parcel_t    lo;
  parcel_t    hi;
  logic [1:0] head_q;
  logic [1:0] tail;
  logic [2:0] cnt_q;
  logic [2:0] n_push;

  assign lo     = {err_i, data_i[15:0]};
  assign hi     = {err_i, data_i[31:16]};
  assign tail   = head_q + cnt_q[1:0];
  assign n_push = !push_i   ? 3'd0 :
                  hi_only_i ? 3'd1 : 3'd2;

  assign h0_o    = mem_q[head_q];
  assign h1_o    = mem_q[head_q + 2'd1];
  assign count_o = cnt_q;

  // Pushes only happen at count<=2, so the tail never hits popped slots.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      head_q <= 2'd0;
      cnt_q  <= 3'd0;
    end else begin
      head_q <= head_q + pop_i;
      cnt_q  <= cnt_q + n_push - {1'b0, pop_i};
    end
    if (push_i && !clr_i) begin
      if (hi_only_i) begin
        mem_q[tail] <= hi;
      end else begin
        mem_q[tail]        <= lo;
        mem_q[tail + 2'd1] <= hi;
      end
    end
  end

endmodule

// File: rtl/rv32ic_fetch_aligner.sv
// rv32ic_fetch_aligner: splits fetch words into instructions.
// Define RV32IC_ALIGNER_RVC_EN for compressed support; else RV32I-only.
module rv32ic_fetch_aligner
  import rv32ic_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  input  logic        fetch_err_i,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_pc_o,
  output logic        ins_rvc_o,
  output logic        ins_err_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        push;
  logic        take;
  logic        valid;

`ifdef RV32IC_ALIGNER_RVC_EN

  parcel_t    h0;
  parcel_t    h1;
  logic [2:0] cnt;
  logic [1:0] pop;
  logic       skip_q;
  logic       skip_d;
  logic       is_short;
  logic       unused_pc0;

  rv32ic_parcel_fifo u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (flush_i),
    .push_i    (push),
    .hi_only_i (skip_q),
    .data_i    (fetch_data_i),
    .err_i     (fetch_err_i),
    .pop_i     (pop),
    .h0_o      (h0),
    .h1_o      (h1),
    .count_o   (cnt)
  );

  assign unused_pc0 = flush_pc_i[0];

  // A faulted head is issued alone so the consumer sees the fault.
  assign is_short = (h0.data[1:0] != RVC_QMASK) | h0.err;
  assign valid    = ~flush_i &
                    (((cnt != 3'd0) & is_short) | (cnt >= 3'd2));

  assign fetch_ready_o = (cnt <= 3'd2) & ~flush_i;
  assign push          = fetch_valid_i & fetch_ready_o;
  assign take          = valid & ins_ready_i;
  assign pop           = !take    ? 2'd0 :
                         is_short ? 2'd1 : 2'd2;

  assign ins_valid_o = valid;
  assign ins_rvc_o   = valid & is_short;
  assign ins_o       = !valid   ? 32'd0 :
                       is_short ? {16'd0, h0.data} :
                                  {h1.data, h0.data};
  assign ins_err_o   = valid & (h0.err | (~is_short & h1.err));
  assign ins_pc_o    = pc_q;

  always_comb begin
    pc_d   = pc_q;
    skip_d = skip_q;
    if (flush_i) begin
      pc_d   = {flush_pc_i[31:1], 1'b0};
      skip_d = flush_pc_i[1];
    end else begin
      if (push) skip_d = 1'b0;
      if (take) pc_d = pc_q + (is_short ? PC_STEP_C : PC_STEP_I);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q   <= {RESET_PC[31:1], 1'b0};
      skip_q <= RESET_PC[1];
    end else begin
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

`else

  logic [31:0] word_q;
  logic        err_q;
  logic        full_q;
  logic        full_d;
  logic [1:0]  unused_pc;

  assign unused_pc = flush_pc_i[1:0];

  assign valid         = full_q & ~flush_i;
  assign take          = valid & ins_ready_i;
  assign fetch_ready_o = (~full_q | take) & ~flush_i;
  assign push          = fetch_valid_i & fetch_ready_o;

  assign ins_valid_o = valid;
  assign ins_rvc_o   = 1'b0;
  assign ins_o       = valid ? word_q : 32'd0;
  assign ins_err_o   = valid & err_q;
  assign ins_pc_o    = pc_q;

  always_comb begin
    pc_d   = pc_q;
    full_d = full_q;
    if (flush_i) begin
      pc_d   = {flush_pc_i[31:2], 2'b00};
      full_d = 1'b0;
    end else begin
      if (take) pc_d = pc_q + PC_STEP_I;
      if (push) full_d = 1'b1;
      else if (take) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q   <= {RESET_PC[31:2], 2'b00};
      full_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      full_q <= full_d;
    end
    if (push) begin
      word_q <= fetch_data_i;
      err_q  <= fetch_err_i;
    end
  end

`endif

endmodule

// File: tb/tb_rv32ic_fetch_aligner.sv
// tb_rv32ic_fetch_aligner: directed self-checking bench
// for both RV32IC and RV32I-only builds of the aligner.
module tb_rv32ic_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fv;
  logic        fr;
  logic [31:0] fdata;
  logic        ferr;
  logic        iv;
  logic        ir;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        rvc;
  logic        ierr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  rv32ic_fetch_aligner dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .flush_i       (flush),
    .flush_pc_i    (flush_pc),
    .fetch_valid_i (fv),
    .fetch_ready_o (fr),
    .fetch_data_i  (fdata),
    .fetch_err_i   (ferr),
    .ins_valid_o   (iv),
    .ins_ready_i   (ir),
    .ins_o         (ins),
    .ins_pc_o      (pc),
    .ins_rvc_o     (rvc),
    .ins_err_o     (ierr)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] p);
    flush = 1'b1;
    flush_pc = p;
    cyc();
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic e);
    int n;
    fv = 1'b1;
    fdata = d;
    ferr = e;
    #1;
    n = 0;
    while (!fr && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL push_timeout fetch_ready=%b exp 1", fr);
    end
    cyc();
    fv = 1'b0;
    ferr = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    ir = 1'b1;
    #1;
    checks++;
    if (iv !== 1'b1) begin
      errors++;
      $display("FAIL pop_valid got %b exp 1", iv);
    end
    cyc();
    ir = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks += 6;
    if (iv !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b exp 0", iv);
    end
    if (ins !== 32'd0) begin
      errors++; $display("FAIL rst_ins got %h exp 0", ins);
    end
    if (rvc !== 1'b0) begin
      errors++; $display("FAIL rst_rvc got %b exp 0", rvc);
    end
    if (ierr !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b exp 0", ierr);
    end
    if (pc !== 32'd0) begin
      errors++; $display("FAIL rst_pc got %h exp 0", pc);
    end
    if (fr !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b exp 1", fr);
    end
  endtask

`ifdef RV32IC_ALIGNER_RVC_EN

  task automatic test_rvc_mix();
    push_word(32'h0001_4501, 1'b0);
    checks += 3;
    if (ins !== 32'h0000_4501 || iv !== 1'b1) begin
      errors++; $display("FAIL mix0_ins got %h exp 00004501", ins);
    end
    if (pc !== 32'd0) begin
      errors++; $display("FAIL mix0_pc got %h exp 0", pc);
    end
    if (rvc !== 1'b1) begin
      errors++; $display("FAIL mix0_rvc got %b exp 1", rvc);
    end
    pop_one();
    checks += 2;
    if (ins !== 32'h0000_0001 || rvc !== 1'b1) begin
      errors++; $display("FAIL mix1_ins got %h exp 00000001", ins);
    end
    if (pc !== 32'd2) begin
      errors++; $display("FAIL mix1_pc got %h exp 2", pc);
    end
    pop_one();
    push_word(32'h0000_0513, 1'b0);
    checks += 2;
    if (ins !== 32'h0000_0513 || rvc !== 1'b0) begin
      errors++; $display("FAIL mix2_ins got %h/%b exp 00000513/0", ins, rvc);
    end
    if (pc !== 32'd4) begin
      errors++; $display("FAIL mix2_pc got %h exp 4", pc);
    end
    pop_one();
  endtask

  task automatic test_straddle();
    do_flush(32'h0);
    push_word(32'h0513_4501, 1'b0);
    checks++;
    if (ins !== 32'h0000_4501 || pc !== 32'd0) begin
      errors++; $display("FAIL strad0 got %h@%h exp 00004501@0", ins, pc);
    end
    pop_one();
    checks++;
    if (iv !== 1'b0 || ins !== 32'd0) begin
      errors++; $display("FAIL strad_partial valid=%b ins=%h exp 0/0", iv, ins);
    end
    push_word(32'h4505_0000, 1'b0);
    checks++;
    if (ins !== 32'h0000_0513 || pc !== 32'd2 || rvc !== 1'b0) begin
      errors++; $display("FAIL strad1 got %h@%h exp 00000513@2", ins, pc);
    end
    pop_one();
    checks++;
    if (ins !== 32'h0000_4505 || pc !== 32'd6 || rvc !== 1'b1) begin
      errors++; $display("FAIL strad2 got %h@%h exp 00004505@6", ins, pc);
    end
    pop_one();
  endtask

  task automatic test_flush();
    do_flush(32'h0);
    push_word(32'h0001_4501, 1'b0);
    flush = 1'b1;
    flush_pc = 32'h102;
    fv = 1'b1;
    fdata = 32'hdead_beef;
    ir = 1'b1;
    #1;
    checks += 2;
    if (iv !== 1'b0) begin
      errors++; $display("FAIL flush_valid got %b exp 0", iv);
    end
    if (fr !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b exp 0", fr);
    end
    cyc();
    flush = 1'b0;
    fv = 1'b0;
    ir = 1'b0;
    #1;
    checks++;
    if (iv !== 1'b0 || pc !== 32'h102) begin
      errors++; $display("FAIL flush_after valid=%b pc=%h exp 0/102", iv, pc);
    end
    push_word(32'h0513_4501, 1'b0);
    checks++;
    if (iv !== 1'b0) begin
      errors++; $display("FAIL flush_skip_wait valid=%b exp 0", iv);
    end
    push_word(32'h0001_0001, 1'b0);
    checks++;
    if (ins !== 32'h0001_0513 || pc !== 32'h102) begin
      errors++; $display("FAIL flush_first got %h@%h exp 00010513@102", ins, pc);
    end
    pop_one();
    checks++;
    if (ins !== 32'h0000_0001 || pc !== 32'h106) begin
      errors++; $display("FAIL flush_next got %h@%h exp 00000001@106", ins, pc);
    end
    pop_one();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [15:0] e [4];
    int k;
    logic acc;
    w[0] = 32'h1001_2001;
    w[1] = 32'h1101_2101;
    w[2] = 32'h1201_2201;
    e[0] = 16'h2001;
    e[1] = 16'h1001;
    e[2] = 16'h2101;
    e[3] = 16'h1101;
    do_flush(32'h0);
    ir = 1'b0;
    fv = 1'b1;
    k = 0;
    fdata = w[0];
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 1) begin
        checks++;
        if (iv !== 1'b1 || ins !== 32'h2001 || pc !== 32'd0) begin
          errors++;
          $display("FAIL bp_hold c=%0d got %b %h@%h exp 1 00002001@0", c, iv, ins, pc);
        end
      end
      if (c >= 2) begin
        checks++;
        if (fr !== 1'b0) begin
          errors++; $display("FAIL bp_ready c=%0d got %b exp 0", c, fr);
        end
      end
      acc = fr;
      cyc();
      if (acc && k < 2) begin
        k++;
        fdata = w[k];
      end
    end
    fv = 1'b0;
    ir = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (iv !== 1'b1 || ins !== {16'd0, e[j]} || pc !== 32'(2 * j)) begin
        errors++;
        $display("FAIL bp_drain j=%0d got %b %h@%h exp 1 %h@%0d", j, iv, ins, pc, e[j], 2 * j);
      end
      cyc();
    end
    ir = 1'b0;
    #1;
    checks++;
    if (iv !== 1'b0) begin
      errors++; $display("FAIL bp_empty got %b exp 0", iv);
    end
  endtask

  task automatic test_fault();
    do_flush(32'h0);
    push_word(32'h0513_4501, 1'b0);
    push_word(32'h4505_0000, 1'b1);
    checks++;
    if (ierr !== 1'b0 || ins !== 32'h4501) begin
      errors++; $display("FAIL fault_head err=%b ins=%h exp 0/4501", ierr, ins);
    end
    pop_one();
    checks++;
    if (iv !== 1'b1 || ierr !== 1'b1 || pc !== 32'd2 || ins !== 32'h0000_0513) begin
      errors++;
      $display("FAIL fault_strad v=%b err=%b %h@%h exp 1 1 00000513@2", iv, ierr, ins, pc);
    end
    do_flush(32'h0);
  endtask

`else

  task automatic test_basic();
    push_word(32'h0001_4501, 1'b0);
    checks += 3;
    if (iv !== 1'b1 || ins !== 32'h0001_4501) begin
      errors++; $display("FAIL basic0 got %b %h exp 1 00014501", iv, ins);
    end
    if (pc !== 32'd0) begin
      errors++; $display("FAIL basic0_pc got %h exp 0", pc);
    end
    if (rvc !== 1'b0) begin
      errors++; $display("FAIL basic0_rvc got %b exp 0", rvc);
    end
    pop_one();
    checks++;
    if (iv !== 1'b0) begin
      errors++; $display("FAIL basic_empty got %b exp 0", iv);
    end
    push_word(32'h0000_0513, 1'b0);
    checks++;
    if (ins !== 32'h0000_0513 || pc !== 32'd4) begin
      errors++; $display("FAIL basic1 got %h@%h exp 00000513@4", ins, pc);
    end
    pop_one();
    exp_pc = 32'd8;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    w[0] = 32'h0011_0093;
    w[1] = 32'h0021_0113;
    w[2] = 32'h0031_8193;
    w[3] = 32'h0042_0213;
    ir = 1'b1;
    fv = 1'b1;
    fdata = w[0];
    cyc();
    for (int i = 1; i < 4; i++) begin
      fdata = w[i];
      #1;
      checks++;
      if (iv !== 1'b1 || ins !== w[i-1] || pc !== exp_pc || fr !== 1'b1) begin
        errors++;
        $display("FAIL b2b i=%0d got %b %h@%h rdy=%b exp 1 %h@%h rdy=1",
                 i, iv, ins, pc, fr, w[i-1], exp_pc);
      end
      exp_pc += 32'd4;
      cyc();
    end
    fv = 1'b0;
    #1;
    checks++;
    if (ins !== w[3] || pc !== exp_pc) begin
      errors++; $display("FAIL b2b_last got %h@%h exp %h@%h", ins, pc, w[3], exp_pc);
    end
    cyc();
    ir = 1'b0;
    exp_pc += 32'd4;
  endtask

  task automatic test_backpressure();
    ir = 1'b0;
    fv = 1'b1;
    fdata = 32'haaaa_0003;
    cyc();
    fdata = 32'hbbbb_0003;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (fr !== 1'b0 || iv !== 1'b1 || ins !== 32'haaaa_0003 || pc !== exp_pc) begin
        errors++;
        $display("FAIL bp_hold c=%0d rdy=%b v=%b %h@%h exp 0 1 aaaa0003@%h",
                 c, fr, iv, ins, pc, exp_pc);
      end
      cyc();
    end
    ir = 1'b1;
    #1;
    checks++;
    if (fr !== 1'b1) begin
      errors++; $display("FAIL bp_release got %b exp 1", fr);
    end
    cyc();
    ir = 1'b0;
    fv = 1'b0;
    exp_pc += 32'd4;
    #1;
    checks++;
    if (ins !== 32'hbbbb_0003 || pc !== exp_pc) begin
      errors++; $display("FAIL bp_next got %h@%h exp bbbb0003@%h", ins, pc, exp_pc);
    end
    pop_one();
    exp_pc += 32'd4;
  endtask

  task automatic test_fault();
    push_word(32'h0000_0013, 1'b1);
    checks++;
    if (iv !== 1'b1 || ierr !== 1'b1 || rvc !== 1'b0 || pc !== exp_pc) begin
      errors++; $display("FAIL fault_set v=%b err=%b rvc=%b pc=%h exp 1 1 0 %h", iv, ierr, rvc, pc, exp_pc);
    end
    pop_one();
    push_word(32'h0000_0013, 1'b0);
    checks++;
    if (ierr !== 1'b0) begin
      errors++; $display("FAIL fault_clear got %b exp 0", ierr);
    end
    pop_one();
  endtask

  task automatic test_flush();
    push_word(32'h1234_5673, 1'b0);
    flush = 1'b1;
    flush_pc = 32'h102;
    fv = 1'b1;
    fdata = 32'hdead_beef;
    ir = 1'b1;
    #1;
    checks += 2;
    if (iv !== 1'b0 || ins !== 32'd0) begin
      errors++; $display("FAIL flush_valid got %b %h exp 0 0", iv, ins);
    end
    if (fr !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b exp 0", fr);
    end
    cyc();
    flush = 1'b0;
    fv = 1'b0;
    ir = 1'b0;
    #1;
    checks++;
    if (iv !== 1'b0 || pc !== 32'h100) begin
      errors++; $display("FAIL flush_after v=%b pc=%h exp 0 100", iv, pc);
    end
    push_word(32'h0513_4501, 1'b0);
    checks++;
    if (ins !== 32'h0513_4501 || pc !== 32'h100 || rvc !== 1'b0) begin
      errors++; $display("FAIL flush_first got %h@%h rvc=%b exp 05134501@100 0", ins, pc, rvc);
    end
    pop_one();
    push_word(32'h0000_0001, 1'b0);
    checks++;
    if (pc !== 32'h104 || rvc !== 1'b0) begin
      errors++; $display("FAIL flush_step got %h rvc=%b exp 104 0", pc, rvc);
    end
    pop_one();
  endtask

  task automatic test_wrap();
    do_flush(32'hffff_fffc);
    push_word(32'h0000_0013, 1'b0);
    checks++;
    if (pc !== 32'hffff_fffc) begin
      errors++; $display("FAIL wrap0 got %h exp fffffffc", pc);
    end
    pop_one();
    push_word(32'h0000_0093, 1'b0);
    checks++;
    if (pc !== 32'd0 || ins !== 32'h0000_0093) begin
      errors++; $display("FAIL wrap1 got %h@%h exp 00000093@0", ins, pc);
    end
    pop_one();
  endtask

`endif

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    flush_pc = 32'd0;
    fv = 1'b0;
    fdata = 32'd0;
    ferr = 1'b0;
    ir = 1'b0;
    exp_pc = 32'd0;
    test_reset();
`ifdef RV32IC_ALIGNER_RVC_EN
    test_rvc_mix();
    test_straddle();
    test_flush();
    test_backpressure();
    test_fault();
`else
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_fault();
    test_flush();
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
